// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order req/gnt/rvalid reads into a small instruction buffer,
// one instruction per cycle to the decoder, with wrong-path squashing on a taken redirect.
module fetch_unit_chk #(
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             rvalid_i,
    input logic [CNT_W-1:0] outstanding_i
);
    // A memory response with nothing outstanding is a protocol violation by the memory.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        rvalid_i |-> (outstanding_i != {CNT_W{1'b0}}));
endmodule

module fetch_unit #(
    parameter int ADDR_W     = 12,
    parameter int INSTR_W    = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int RESET_PC   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               load_pc,
    input  logic [ADDR_W-1:0]  load_pc_val,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  instr_pc
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d, prd_q, prd_d, pwr_q, pwr_d;
    logic [INSTR_W-1:0] data_q [FIFO_DEPTH];
    logic [INSTR_W-1:0] data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]  ipc_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0]  ipc_d  [FIFO_DEPTH];
    logic [ADDR_W-1:0]  rpc_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0]  rpc_d  [FIFO_DEPTH];
    logic               imem_req_q, imem_req_d, instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instruction_q, instruction_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

    logic               consume_s, redirect_s, gnt_s, rv_s, drop_word_s, push_s;
    logic [SUM_W-1:0]   occupancy_s;

    // Next-state logic for request tracking, instruction buffer, FSM and registered outputs.
    always_comb begin
        consume_s   = instr_valid_q && !stall;
        redirect_s  = consume_s && load_pc;
        gnt_s       = imem_req_q && imem_gnt;
        rv_s        = imem_rvalid && (out_q != {CNT_W{1'b0}});
        drop_word_s = rv_s && (drop_q != {CNT_W{1'b0}});
        push_s      = rv_s && !drop_word_s && !redirect_s;

        out_d = out_q + CNT_W'(gnt_s) - CNT_W'(rv_s);

        // Request PCs travel in order alongside the requests so instr_pc stays exact across redirects.
        rpc_d = rpc_q;
        if (gnt_s) begin
            rpc_d[pwr_q] = fetch_pc_q;
        end else begin
            rpc_d[pwr_q] = rpc_q[pwr_q];
        end
        pwr_d = pwr_q + PTR_W'(gnt_s);
        prd_d = prd_q + PTR_W'(rv_s);

        data_d = data_q;
        ipc_d  = ipc_q;
        if (push_s) begin
            data_d[wr_q] = imem_rdata;
            ipc_d[wr_q]  = rpc_q[prd_q];
        end else begin
            data_d[wr_q] = data_q[wr_q];
        end

        if (redirect_s) begin
            cnt_d      = {CNT_W{1'b0}};
            rd_d       = {PTR_W{1'b0}};
            wr_d       = {PTR_W{1'b0}};
            drop_d     = out_d;
            fetch_pc_d = load_pc_val;
        end else begin
            cnt_d      = cnt_q + CNT_W'(push_s) - CNT_W'(consume_s);
            rd_d       = rd_q + PTR_W'(consume_s);
            wr_d       = wr_q + PTR_W'(push_s);
            drop_d     = drop_q - CNT_W'(drop_word_s);
            fetch_pc_d = fetch_pc_q + ADDR_W'(gnt_s);
        end

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (redirect_s && (out_d != {CNT_W{1'b0}})) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (drop_d == {CNT_W{1'b0}}) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stale responses still count against capacity until they have drained.
        occupancy_s   = SUM_W'(out_d) + SUM_W'(cnt_d) + SUM_W'(drop_d);
        imem_req_d    = (state_d != ST_IDLE) && (occupancy_s < SUM_W'(FIFO_DEPTH));
        instr_valid_d = (cnt_d != {CNT_W{1'b0}}) && (state_d != ST_FLUSH);
        if (instr_valid_d) begin
            instruction_d = data_d[rd_d];
            instr_pc_d    = ipc_d[rd_d];
        end else begin
            instruction_d = {INSTR_W{1'b0}};
            instr_pc_d    = {ADDR_W{1'b0}};
        end
    end

    // State, counter, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= ADDR_W'(RESET_PC);
            out_q         <= {CNT_W{1'b0}};
            drop_q        <= {CNT_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            rd_q          <= {PTR_W{1'b0}};
            wr_q          <= {PTR_W{1'b0}};
            prd_q         <= {PTR_W{1'b0}};
            pwr_q         <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= {INSTR_W{1'b0}};
                ipc_q[i]  <= {ADDR_W{1'b0}};
                rpc_q[i]  <= {ADDR_W{1'b0}};
            end
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instruction_q <= {INSTR_W{1'b0}};
            instr_pc_q    <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            out_q         <= out_d;
            drop_q        <= drop_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            prd_q         <= prd_d;
            pwr_q         <= pwr_d;
            data_q        <= data_d;
            ipc_q         <= ipc_d;
            rpc_q         <= rpc_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            instruction_q <= instruction_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = instr_valid_q;
    assign instruction = instruction_q;
    assign instr_pc    = instr_pc_q;

    fetch_unit_chk #(.CNT_W(CNT_W)) u_chk (
        .clk           (clk),
        .rst_n         (rst_n),
        .rvalid_i      (imem_rvalid),
        .outstanding_i (out_q)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory timing, stalls and redirects; a program-order
// model predicts every instruction the decoder should see, checked by a separate monitor.
module tb_fetch_unit;
    localparam int AW = 12;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req, imem_gnt, imem_rvalid;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          stall, load_pc;
    logic [AW-1:0] load_pc_val;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [AW-1:0] instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .FIFO_DEPTH(2), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .load_pc     (load_pc),
        .load_pc_val (load_pc_val),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc)
    );

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } mreq_t;

    mreq_t         mq[$];
    logic [AW-1:0] exp_q[$];
    int            errors = 0, checks = 0, cyc = 0, consumes = 0, c0;
    int            gnt_pct = 100, stall_pct = 0, redir_pct = 0, lat_max = 1;
    logic          force_redir = 1'b0;
    logic [AW-1:0] force_tgt = 12'h000;
    logic [AW-1:0] arch_pc;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'h1000 | {4'h0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of memory, decoder and program-order model activity, driven at the falling edge.
    task automatic step();
        mreq_t m;
        @(negedge clk);
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        imem_gnt = ($urandom_range(99, 0) < gnt_pct);
        if (imem_req && imem_gnt) begin
            m.due  = cyc + int'($urandom_range(lat_max, 1));
            m.addr = imem_addr;
            mq.push_back(m);
        end
        stall       = ($urandom_range(99, 0) < stall_pct);
        load_pc_val = AW'($urandom);
        load_pc     = 1'b0;
        if (instr_valid && !stall) begin
            consumes++;
            if (force_redir) begin
                load_pc     = 1'b1;
                load_pc_val = force_tgt;
                force_redir = 1'b0;
            end else begin
                load_pc = ($urandom_range(99, 0) < redir_pct);
            end
            arch_pc = load_pc ? load_pc_val : arch_pc + 12'h001;
            exp_q.push_back(arch_pc);
        end else begin
            load_pc = ($urandom_range(99, 0) < redir_pct);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   imem_req,    0);
        check({tag, "_addr"},  imem_addr,   0);
        check({tag, "_instr"}, instruction, 0);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_pc"},    instr_pc,    0);
    endtask

    // Monitor: the buffer head must always be the next instruction in program order.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got pc %0h expected none", instr_pc);
                end else begin
                    check("instr_pc", instr_pc, exp_q[0]);
                    check("instruction", instruction, mem_word(exp_q[0]));
                    if (!stall) void'(exp_q.pop_front());
                end
            end else begin
                check("nop_when_invalid", instruction, 0);
            end
        end
    end

    initial begin
        stall = 1'b0; load_pc = 1'b0; load_pc_val = 12'h000;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
        arch_pc = 12'h000;
        exp_q.push_back(12'h000);
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // 1-cycle memory, no stall: first valid three cycles after release.
        step(); check("valid_c1", instr_valid, 0);
        step(); check("valid_c2", instr_valid, 0);
        step(); check("valid_c3", instr_valid, 1);
        repeat (20) step();

        // Stall: buffer fills and requests stop; head held (monitor).
        stall_pct = 100;
        repeat (5) step();
        check("stall_req_low", imem_req, 0);
        check("stall_valid", instr_valid, 1);
        stall_pct = 0;
        c0 = consumes;
        repeat (10) step();
        check("stall_release_progress", consumes > c0, 1);

        // Taken jump with 3-cycle memory, then redirect near the top of the address space.
        lat_max = 3;
        force_tgt = 12'h040; force_redir = 1'b1;
        repeat (25) step();
        check("jmp_target_reached", force_redir, 0);
        force_tgt = 12'hFFE; force_redir = 1'b1;
        repeat (25) step();
        check("wrap_redirect_taken", force_redir, 0);

        // Random traffic, including load_pc pulses while nothing is consumed.
        gnt_pct = 70; stall_pct = 30; redir_pct = 15; lat_max = 4;
        c0 = consumes;
        repeat (2000) step();
        check("random_progress", consumes > c0 + 100, 1);

        // Reset mid-transaction with a full buffer and requests in flight.
        gnt_pct = 100; stall_pct = 100; redir_pct = 0; lat_max = 3;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        imem_rvalid = 1'b0; imem_gnt = 1'b0; stall = 1'b0; load_pc = 1'b0;
        #1;
        check_reset_outputs("midrst");
        mq.delete();
        exp_q.delete();
        arch_pc = 12'h000;
        exp_q.push_back(12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stall_pct = 0;
        c0 = consumes;
        repeat (30) step();
        check("restart_progress", consumes > c0 + 5, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
